mem_port_arbiter: RTL

- Parametrised N-channel arbiter that lets several line-based caches share one slow-memory port.
- Typical clients: I-cache, D-cache, and future prefetch/victim buffers.
- Sits between the cache mem_* interfaces and the single off-chip memory interface at the CHIP boundary.
- Adds two arbitration modes and registered, single-pulse per-channel completion, which the current one-memory-per-cache wiring lacks.

---
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one slow line-memory port between NUM_CH cache channels.
// Round-robin or fixed-priority grant, registered one-cycle completion per channel.
module mem_port_arbiter #(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 28,
  parameter int LINE_W   = 128,
  parameter int ARB_MODE = 0
) (
  input  logic                       clk,
  input  logic                       proc_reset,
  input  logic [NUM_CH-1:0]          ch_read,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*LINE_W-1:0]   ch_wdata,
  output logic [LINE_W-1:0]          ch_rdata,
  output logic [NUM_CH-1:0]          ch_ready,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [LINE_W-1:0]          mem_wdata,
  input  logic [LINE_W-1:0]          mem_rdata,
  input  logic                       mem_ready,
  output logic                       busy
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state_reg, state_next;
  logic [CH_W-1:0]   grant_reg, last_grant_reg, winner;
  logic [NUM_CH-1:0] req, ready_next;
  logic              any_req, found;
  int                idx;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      assign req[gi]        = ch_read[gi] | ch_write[gi];
      assign ready_next[gi] = (state_reg == BUSY) && mem_ready && (grant_reg == CH_W'(gi));
    end
  endgenerate

  assign any_req = |req;
  assign busy    = (state_reg != IDLE);

  // Winner search; round-robin starts just after the last granted channel.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    if (ARB_MODE == 1) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!found && req[k]) begin
          winner = CH_W'(k);
          found  = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        idx = (int'(last_grant_reg) + k) % NUM_CH;
        if (!found && req[idx]) begin
          winner = CH_W'(idx);
          found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = BUSY;
      BUSY:    if (mem_ready) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) state_reg <= IDLE;
    else            state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      grant_reg      <= '0;
      last_grant_reg <= CH_W'(NUM_CH - 1);
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      ch_rdata       <= '0;
      ch_ready       <= '0;
    end else begin
      ch_ready <= ready_next;
      if (state_reg == IDLE && any_req) begin
        grant_reg      <= winner;
        last_grant_reg <= winner;
        mem_addr       <= ch_addr[int'(winner)*ADDR_W +: ADDR_W];
        mem_wdata      <= ch_wdata[int'(winner)*LINE_W +: LINE_W];
        // A simultaneous read+write issues the write; the read waits for a later grant.
        mem_write      <= ch_write[winner];
        mem_read       <= ~ch_write[winner];
      end else if (state_reg == BUSY && mem_ready) begin
        if (mem_read) ch_rdata <= mem_rdata;
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end
    end
  end
endmodule
